// File: rtl/ctrl_sequencer_gen2.sv
// ctrl_sequencer_gen2: CPU control FSM (fetch/decode/dispatch/execute) with wait timeouts, CALL depth guard, sticky fault.
// Strobes are registered from next state (high exactly while in their state); SINGLE_STEP_EN adds i_step gating of FETCH.
module ctrl_sequencer_gen2 #(
    parameter int OPW         = 6,
    parameter int NFLAGS      = 4,
    parameter int NUNITS      = 2,
    parameter int STACK_DEPTH = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bgn,
    input  logic              i_load_done,
    input  logic [OPW-1:0]    i_opcode,
    input  logic [NFLAGS-1:0] i_flags,
    input  logic              i_reg_sel,
    input  logic [NUNITS-1:0] i_unit_done,
`ifdef SINGLE_STEP_EN
    input  logic              i_step,
`endif
    output logic              o_read_file,
    output logic              o_get_addr,
    output logic              o_incr_pc,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [1:0]        o_reg_ld,
    output logic [1:0]        o_reg_st,
    output logic              o_acc_ld,
    output logic              o_acc_st,
    output logic              o_pc_from_imm,
    output logic              o_pc_from_stack,
    output logic              o_push,
    output logic              o_pop,
    output logic [NUNITS-1:0] o_unit_start,
    output logic              o_unit_save,
    output logic              o_fin,
    output logic              o_fault,
    output logic [2:0]        o_fault_code
);
    localparam int SW     = OPW - 3;
    localparam int DW     = $clog2(STACK_DEPTH + 1);
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [4:0] {
        S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_DISPATCH,
        S_MEM_ST, S_MEM_WR, S_MEM_RD, S_MEM_LD,
        S_BR_EVAL, S_BR_TAKE, S_CALL_PUSH,
        S_RET_POP, S_RET_WAIT, S_RET_JUMP, S_RET_WAIT2,
        S_EXEC_START, S_EXEC_WAIT, S_EXEC_SAVE,
        S_HALT, S_FAULT
`ifdef SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t S_AFTER = S_STEP_WAIT;
`else
    localparam state_t S_AFTER = S_FETCH;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_code;
    logic [2:0]        w_code;
    logic [SW-1:0]     r_sub;
    logic              r_sel;
    logic [DW-1:0]     r_depth;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        w_cls;
    logic [SW-1:0]     w_sub;
    logic              w_sel;
    logic [NUNITS-1:0] w_unit_oh;
    logic              w_flag_hit;
    logic              w_unit_done;
    logic              w_timeout;

    // Operand fields come live from the opcode in DISPATCH, from the captured copy afterwards.
    assign w_cls       = i_opcode[OPW-1:OPW-3];
    assign w_sub       = (r_state == S_DISPATCH) ? i_opcode[SW-1:0] : r_sub;
    assign w_sel       = (r_state == S_DISPATCH) ? i_reg_sel : r_sel;
    assign w_unit_oh   = NUNITS'(1) << w_sub;
    assign w_flag_hit  = |(i_flags & (NFLAGS'(1) << w_sub));
    assign w_unit_done = |(i_unit_done & w_unit_oh);
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CW'(TO_LIM));

    always_comb begin
        w_next = r_state;
        w_code = r_code;
        case (r_state)
            S_IDLE:     if (i_bgn) w_next = S_LOAD;
            S_LOAD: begin
                if (i_load_done) w_next = S_FETCH;
                else if (w_timeout) begin
                    w_next = S_FAULT;
                    w_code = 3'd2;
                end
            end
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = S_DISPATCH;
            S_DISPATCH: begin
                case (w_cls)
                    3'b000: w_next = S_HALT;
                    3'b001: w_next = w_sub[0] ? S_MEM_ST : S_MEM_RD;
                    3'b010: w_next = S_BR_EVAL;
                    3'b011: begin
                        if (r_depth == DW'(STACK_DEPTH)) begin
                            w_next = S_FAULT;
                            w_code = 3'd3;
                        end else w_next = S_CALL_PUSH;
                    end
                    3'b100: begin
                        if (r_depth == '0) begin
                            w_next = S_FAULT;
                            w_code = 3'd4;
                        end else w_next = S_RET_POP;
                    end
                    3'b101: begin
                        if (32'(w_sub) >= NUNITS) begin
                            w_next = S_FAULT;
                            w_code = 3'd5;
                        end else w_next = S_EXEC_START;
                    end
                    default: begin
                        w_next = S_FAULT;
                        w_code = 3'd1;
                    end
                endcase
            end
            S_MEM_ST:   w_next = S_MEM_WR;
            S_MEM_WR:   w_next = S_AFTER;
            S_MEM_RD:   w_next = S_MEM_LD;
            S_MEM_LD:   w_next = S_AFTER;
            S_BR_EVAL: begin
                if (&w_sub) w_next = S_BR_TAKE;
                else if (32'(w_sub) >= NFLAGS) begin
                    w_next = S_FAULT;
                    w_code = 3'd1;
                end else if (w_flag_hit) w_next = S_BR_TAKE;
                else w_next = S_AFTER;
            end
            S_BR_TAKE:    w_next = S_AFTER;
            S_CALL_PUSH:  w_next = S_BR_TAKE;
            S_RET_POP:    w_next = S_RET_WAIT;
            S_RET_WAIT:   w_next = S_RET_JUMP;
            S_RET_JUMP:   w_next = S_RET_WAIT2;
            S_RET_WAIT2:  w_next = S_AFTER;
            S_EXEC_START: w_next = S_EXEC_WAIT;
            S_EXEC_WAIT: begin
                if (w_unit_done) w_next = S_EXEC_SAVE;
                else if (w_timeout) begin
                    w_next = S_FAULT;
                    w_code = 3'd2;
                end
            end
            S_EXEC_SAVE:  w_next = S_AFTER;
            S_HALT:       w_next = S_HALT;
            S_FAULT:      w_next = S_FAULT;
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT:  if (i_step) w_next = S_FETCH;
`endif
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_code          <= '0;
            r_sub           <= '0;
            r_sel           <= 1'b0;
            r_depth         <= '0;
            r_cnt           <= '0;
            o_read_file     <= 1'b0;
            o_get_addr      <= 1'b0;
            o_incr_pc       <= 1'b0;
            o_mem_read      <= 1'b0;
            o_mem_write     <= 1'b0;
            o_reg_ld        <= '0;
            o_reg_st        <= '0;
            o_acc_ld        <= 1'b0;
            o_acc_st        <= 1'b0;
            o_pc_from_imm   <= 1'b0;
            o_pc_from_stack <= 1'b0;
            o_push          <= 1'b0;
            o_pop           <= 1'b0;
            o_unit_start    <= '0;
            o_unit_save     <= 1'b0;
            o_fin           <= 1'b0;
            o_fault         <= 1'b0;
            o_fault_code    <= '0;
        end else begin
            r_state <= w_next;
            r_code  <= w_code;
            if (r_state == S_DISPATCH) begin
                r_sub <= i_opcode[SW-1:0];
                r_sel <= i_reg_sel;
            end
            if (r_state == S_DISPATCH && w_next == S_CALL_PUSH) r_depth <= r_depth + 1'b1;
            else if (r_state == S_DISPATCH && w_next == S_RET_POP) r_depth <= r_depth - 1'b1;
            // Wait counter restarts on each entry to a wait state and runs while the state holds.
            if ((w_next == S_LOAD && r_state != S_LOAD) ||
                (w_next == S_EXEC_WAIT && r_state != S_EXEC_WAIT))
                r_cnt <= '0;
            else if (w_next == r_state && (r_state == S_LOAD || r_state == S_EXEC_WAIT))
                r_cnt <= r_cnt + 1'b1;
            o_read_file     <= (w_next == S_LOAD);
            o_get_addr      <= (w_next == S_FETCH);
            o_incr_pc       <= (w_next == S_DECODE);
            o_mem_read      <= (w_next == S_MEM_RD);
            o_mem_write     <= (w_next == S_MEM_WR);
            o_reg_ld        <= (w_next == S_MEM_LD && !w_sub[1]) ? (w_sel ? 2'b01 : 2'b10) : 2'b00;
            o_reg_st        <= (w_next == S_MEM_ST && !w_sub[1]) ? (w_sel ? 2'b01 : 2'b10) : 2'b00;
            o_acc_ld        <= (w_next == S_MEM_LD) && w_sub[1];
            o_acc_st        <= (w_next == S_MEM_ST) && w_sub[1];
            o_pc_from_imm   <= (w_next == S_BR_TAKE);
            o_pc_from_stack <= (w_next == S_RET_JUMP);
            o_push          <= (w_next == S_CALL_PUSH);
            o_pop           <= (w_next == S_RET_POP);
            o_unit_start    <= (w_next == S_EXEC_START) ? w_unit_oh : '0;
            o_unit_save     <= (w_next == S_EXEC_SAVE);
            o_fin           <= (w_next == S_HALT);
            o_fault         <= (w_next == S_FAULT);
            o_fault_code    <= w_code;
        end
    end
endmodule

// File: tb/tb_ctrl_sequencer_gen2.sv
// Bench for ctrl_sequencer_gen2: per-instruction expected strobe traces from a behavioural model, random programs.
module tb_ctrl_sequencer_gen2;
    typedef logic [22:0] vec_t;
    localparam vec_t V_RF   = 23'h400000, V_GA   = 23'h200000, V_IPC  = 23'h100000;
    localparam vec_t V_MR   = 23'h080000, V_MW   = 23'h040000;
    localparam vec_t V_RLDX = 23'h020000, V_RLDY = 23'h010000, V_RSTX = 23'h008000, V_RSTY = 23'h004000;
    localparam vec_t V_ALD  = 23'h002000, V_AST  = 23'h001000, V_PCI  = 23'h000800, V_PCS  = 23'h000400;
    localparam vec_t V_PUSH = 23'h000200, V_POP  = 23'h000100, V_US1  = 23'h000080, V_US0  = 23'h000040;
    localparam vec_t V_SAVE = 23'h000020, V_FIN  = 23'h000010, V_FLT  = 23'h000008;
    localparam int TMO = 16, DEPTH = 8;

    logic       clk = 0, rst = 0, bgn = 0, load_done = 0, reg_sel = 0;
    logic [5:0] opcode = '0;
    logic [3:0] flags = '0;
    logic [1:0] unit_done = '0;
    logic read_file, get_addr, incr_pc, mem_read, mem_write, acc_ld, acc_st;
    logic pc_from_imm, pc_from_stack, push, pop, unit_save, fin, fault;
    logic [1:0] reg_ld, reg_st, unit_start;
    logic [2:0] fault_code;
    vec_t obs;

    int n_cmp = 0, n_err = 0, m_depth = 0;
    bit m_term = 0;

    always #5 clk = ~clk;

    ctrl_sequencer_gen2 #(.OPW(6), .NFLAGS(4), .NUNITS(2), .STACK_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_bgn(bgn), .i_load_done(load_done), .i_opcode(opcode),
        .i_flags(flags), .i_reg_sel(reg_sel), .i_unit_done(unit_done),
        .o_read_file(read_file), .o_get_addr(get_addr), .o_incr_pc(incr_pc),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_reg_ld(reg_ld), .o_reg_st(reg_st),
        .o_acc_ld(acc_ld), .o_acc_st(acc_st), .o_pc_from_imm(pc_from_imm),
        .o_pc_from_stack(pc_from_stack), .o_push(push), .o_pop(pop), .o_unit_start(unit_start),
        .o_unit_save(unit_save), .o_fin(fin), .o_fault(fault), .o_fault_code(fault_code)
    );

    assign obs = {read_file, get_addr, incr_pc, mem_read, mem_write, reg_ld, reg_st, acc_ld, acc_st,
                  pc_from_imm, pc_from_stack, push, pop, unit_start, unit_save, fin, fault, fault_code};

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input vec_t e, input string tag);
        @(posedge clk);
        #1;
        check_eq(tag, obs, e);
    endtask

    task automatic hold(input vec_t e);
        for (int k = 0; k < 3; k++) begin
            bgn = 1'($urandom);
            step(e, "hold");
        end
        bgn = 0;
    endtask

    task automatic do_reset();
        rst = 1; bgn = 0; load_done = 0; unit_done = '0;
        #2;
        check_eq("rst_async", obs, '0);
        @(posedge clk);
        #1;
        rst = 0; m_depth = 0; m_term = 0;
        step('0, "idle");
    endtask

    task automatic start_prog(input int d);
        bgn = 1;
        step(V_RF, "load");
        bgn = 0;
        for (int k = 1; k <= d && k < TMO; k++) step(V_RF, "load");
        if (d >= TMO) begin
            step(V_FLT | 3'd2, "load_tmo");
            m_term = 1;
            hold(V_FLT | 3'd2);
        end else begin
            load_done = 1;
            step(V_GA, "fetch");
            load_done = 0;
        end
    endtask

    // Expected trace after DISPATCH, derived from the instruction semantics.
    task automatic do_instr(input logic [5:0] op, input logic sel, input logic [3:0] fl,
                            input int dd, input bit noise);
        vec_t q_exp[$];
        logic [1:0] q_ud[$];
        logic [2:0] cls, sub;
        logic [1:0] v;
        int u;
        cls = op[5:3]; sub = op[2:0];
        opcode = op; reg_sel = sel; flags = fl;
        step(V_IPC, "decode");
        step('0, "dispatch");
        case (cls)
            3'd0: q_exp.push_back(V_FIN);
            3'd1: begin
                if (sub[0]) begin
                    q_exp.push_back(sub[1] ? V_AST : (sel ? V_RSTY : V_RSTX));
                    q_exp.push_back(V_MW);
                end else begin
                    q_exp.push_back(V_MR);
                    q_exp.push_back(sub[1] ? V_ALD : (sel ? V_RLDY : V_RLDX));
                end
                q_exp.push_back(V_GA);
            end
            3'd2: begin
                q_exp.push_back('0);
                if (sub == 3'd7 || (sub < 3'd4 && fl[sub[1:0]])) begin
                    q_exp.push_back(V_PCI); q_exp.push_back(V_GA);
                end else if (sub >= 3'd4) q_exp.push_back(V_FLT | 3'd1);
                else q_exp.push_back(V_GA);
            end
            3'd3: begin
                if (m_depth == DEPTH) q_exp.push_back(V_FLT | 3'd3);
                else begin
                    m_depth++;
                    q_exp.push_back(V_PUSH); q_exp.push_back(V_PCI); q_exp.push_back(V_GA);
                end
            end
            3'd4: begin
                if (m_depth == 0) q_exp.push_back(V_FLT | 3'd4);
                else begin
                    m_depth--;
                    q_exp.push_back(V_POP); q_exp.push_back('0); q_exp.push_back(V_PCS);
                    q_exp.push_back('0); q_exp.push_back(V_GA);
                end
            end
            3'd5: begin
                if (sub >= 3'd2) q_exp.push_back(V_FLT | 3'd5);
                else begin
                    u = int'(sub[0]);
                    q_exp.push_back(u == 1 ? V_US1 : V_US0);
                    q_ud.push_back(2'($urandom));
                    if (dd >= TMO) begin
                        for (int j = 1; j <= TMO; j++) q_exp.push_back('0);
                        q_exp.push_back(V_FLT | 3'd2);
                    end else begin
                        for (int j = 1; j <= dd + 1; j++) q_exp.push_back('0);
                        q_exp.push_back(V_SAVE); q_exp.push_back(V_GA);
                    end
                    for (int j = 1; j < q_exp.size(); j++) begin
                        v = 2'($urandom);
                        v[u] = (j == 1) ? noise : (dd < TMO && j >= dd + 2);
                        q_ud.push_back(v);
                    end
                end
            end
            default: q_exp.push_back(V_FLT | 3'd1);
        endcase
        while (q_ud.size() < q_exp.size()) q_ud.push_back(2'($urandom));
        for (int j = 0; j < q_exp.size(); j++) begin
            unit_done = q_ud[j];
            step(q_exp[j], $sformatf("cls%0d_sub%0d_c%0d", cls, sub, j));
        end
        unit_done = '0;
        if (q_exp[q_exp.size()-1] != V_GA) begin
            m_term = 1;
            hold(q_exp[q_exp.size()-1]);
        end
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        logic [2:0] c, s;
        r = $urandom_range(0, 99);
        s = 3'($urandom);
        if (r < 2) c = 3'd0;
        else if (r < 27) c = 3'd1;
        else if (r < 45) begin
            c = 3'd2;
            if ($urandom_range(0, 9) != 0) s = s[2] ? 3'd7 : {1'b0, s[1:0]};
        end else if (r < 65) c = 3'd3;
        else if (r < 80) c = 3'd4;
        else if (r < 98) begin
            c = 3'd5;
            if ($urandom_range(0, 19) != 0) s = {2'b00, s[0]};
        end else c = 3'(6 + $urandom_range(0, 1));
        return {c, s};
    endfunction

    function automatic int rand_dd();
        int r;
        r = $urandom_range(0, 39);
        if (r < 36) return $urandom_range(0, 8);
        if (r < 38) return 15;
        return $urandom_range(16, 20);
    endfunction

    initial begin
        #1;
        // Basic: load_done after 3 cycles, then HALT.
        do_reset();
        start_prog(3);
        do_instr(6'b000_000, 0, 4'h0, 0, 0);

        // Register/accumulator loads and stores.
        do_reset();
        start_prog(0);
        do_instr(6'b001_000, 1, 4'h0, 0, 0);
        do_instr(6'b001_001, 1, 4'h0, 0, 0);
        do_instr(6'b001_000, 0, 4'h0, 0, 0);
        do_instr(6'b001_011, 0, 4'h0, 0, 0);
        do_instr(6'b001_010, 1, 4'h0, 0, 0);

        // Branches with flags=0100, then an out-of-range flag index.
        do_instr(6'b010_010, 0, 4'b0100, 0, 0);
        do_instr(6'b010_000, 0, 4'b0100, 0, 0);
        do_instr(6'b010_111, 0, 4'b0000, 0, 0);
        do_instr(6'b010_101, 0, 4'b0100, 0, 0);

        // Call depth guard and empty-stack return.
        do_reset();
        start_prog(1);
        for (int k = 0; k < DEPTH; k++) do_instr(6'b011_000, 0, 4'h0, 0, 0);
        do_instr(6'b011_000, 0, 4'h0, 0, 0);
        do_reset();
        start_prog(0);
        do_instr(6'b100_000, 0, 4'h0, 0, 0);

        // Exec units: normal, done exactly at the timeout, timeout, bad index.
        do_reset();
        start_prog(2);
        do_instr(6'b011_000, 0, 4'h0, 0, 0);
        do_instr(6'b100_000, 0, 4'h0, 0, 0);
        do_instr(6'b101_001, 0, 4'h0, 5, 0);
        do_instr(6'b101_000, 0, 4'h0, 15, 1);
        do_instr(6'b101_001, 0, 4'h0, 16, 1);
        do_reset();
        start_prog(0);
        do_instr(6'b101_010, 0, 4'h0, 0, 0);
        do_reset();
        start_prog(0);
        do_instr(6'b110_000, 0, 4'h0, 0, 0);

        // Load timeout and its boundary.
        do_reset();
        start_prog(16);
        do_reset();
        start_prog(15);
        do_instr(6'b000_000, 0, 4'h0, 0, 0);

        // Asynchronous reset in the middle of an exec wait, then restart.
        do_reset();
        start_prog(1);
        opcode = 6'b101_000;
        unit_done = '0;
        step(V_IPC, "decode");
        step('0, "dispatch");
        step(V_US0, "ustart");
        step('0, "uwait");
        step('0, "uwait");
        #3 rst = 1;
        #1 check_eq("rst_mid", obs, '0);
        @(posedge clk);
        #1;
        rst = 0; m_depth = 0; m_term = 0;
        step('0, "idle2");
        start_prog(2);
        do_instr(6'b000_000, 0, 4'h0, 0, 0);

        // Random programs.
        for (int s = 0; s < 30; s++) begin
            do_reset();
            start_prog($urandom_range(0, 5));
            for (int i = 0; i < 40 && !m_term; i++)
                do_instr(rand_op(), 1'($urandom), 4'($urandom), rand_dd(), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_sequencer_gen2.md
Name: ctrl_sequencer_gen2

Overview:
Parametrised successor of the CPU control FSM. It runs the fetch/decode/dispatch/execute sequence for the general-purpose processor over a configurable set of execution units (ALU, crypto core, and others). It adds per-wait timeouts, a call-stack depth guard, and a sticky fault state with a code. It sits between the instruction memory/PC block and the datapath units, and drives the same kinds of strobes as the current control unit.

Parameters:
OPW, 6, opcode width (>=5); opcode[OPW-1:OPW-3] = class, opcode[OPW-4:0] = sub.
NFLAGS, 4, width of the flags input; branch sub-field selects the flag index.
NUNITS, 2, number of execution units with start/done handshake.
STACK_DEPTH, 8, maximum nested CALL depth.
TIMEOUT, 1024, maximum cycles in any wait state; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
bgn  in  1  start pulse, sampled in IDLE
load_done  in  1  instruction memory finished loading from file
opcode  in  OPW  current instruction opcode, valid from DISPATCH onward
flags  in  NFLAGS  condition flags
reg_sel  in  1  selects register X (0) or Y (1)
unit_done  in  NUNITS  per-unit completion, level
read_file  out  1  request to load program file
get_addr  out  1  PC drives instruction address
incr_pc  out  1  PC increment; also instruction memory read
mem_read  out  1  data memory read
mem_write  out  1  data memory write
reg_ld  out  2  {X,Y} load from data bus
reg_st  out  2  {X,Y} drive to data bus
acc_ld  out  1  accumulator load
acc_st  out  1  accumulator store
pc_from_imm  out  1  PC <- branch target
pc_from_stack  out  1  PC <- popped address
push  out  1  stack push
pop  out  1  stack pop
unit_start  out  NUNITS  one-hot start pulse
unit_save  out  1  save unit result to accumulator
fin  out  1  HALT reached, sticky
fault  out  1  fault, sticky
fault_code  out  3  1 illegal opcode, 2 timeout, 3 stack overflow, 4 stack underflow, 5 bad unit index

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0; depth=0; timeout counter=0. Reset mid-operation aborts immediately; no strobe survives.
- Outputs are registered and decoded from next_state: each strobe is high exactly during the cycles the FSM occupies the associated state. Only one unit_start bit is ever high.
- IDLE -> LOAD when bgn=1. LOAD: read_file=1, wait for load_done -> FETCH.
- FETCH: get_addr=1 -> DECODE.
- DECODE: incr_pc=1 -> DISPATCH.
- DISPATCH routes on class:
  - 000 -> HALT.
  - 001 -> MEM.
  - 010 -> BR_EVAL.
  - 011 -> CALL_PUSH.
  - 100 -> RET_POP.
  - 101 -> EXEC_START.
  - 110/111 -> FAULT code 1.
- MEM (2 cycles, then FETCH), sub[1]=0 selects register (reg_sel picks X/Y), sub[1]=1 selects accumulator:
  - Store (sub[0]=1): ST cycle (reg_st/acc_st), then WR cycle (mem_write).
  - Load (sub[0]=0): RD cycle (mem_read), then LD cycle (reg_ld/acc_ld).
- BR_EVAL:
  - sub all ones: branch always taken.
  - Else idx=sub; idx>=NFLAGS -> FAULT code 1.
  - Taken when flags[idx]=1 -> BR_TAKE (pc_from_imm) -> FETCH.
  - Not taken -> FETCH directly.
- CALL:
  - depth==STACK_DEPTH at DISPATCH -> FAULT code 3.
  - Else CALL_PUSH (push, depth+1) -> BR_TAKE.
- RET:
  - depth==0 -> FAULT code 4.
  - Else RET_POP (pop, depth-1) -> RET_WAIT (1 idle cycle, data memory latency) -> RET_JUMP (pc_from_stack) -> RET_WAIT2 -> FETCH.
- EXEC:
  - sub>=NUNITS -> FAULT code 5.
  - Else EXEC_START (unit_start[sub], 1 cycle) -> EXEC_WAIT until unit_done[sub]=1 -> EXEC_SAVE (unit_save) -> FETCH.
  - unit_done sampled no earlier than the cycle after the start pulse.
- Timeout: the counter clears on entering LOAD or EXEC_WAIT and increments each cycle spent waiting. If it reaches TIMEOUT with done still low -> FAULT code 2. If done and the timeout coincide, done wins.
- HALT: fin=1 and held; leaves only via reset.
- FAULT: fault=1, fault_code held; leaves only via reset. fin stays 0.
- bgn is ignored outside IDLE.

Optional Feature:
SINGLE_STEP_EN: when defined, adds input step (1 bit) and state STEP_WAIT. Every transition that would enter FETCH from a completed instruction enters STEP_WAIT instead, and the FSM proceeds to FETCH on a cycle with step=1. The first FETCH after LOAD is not gated. STEP_WAIT does not count toward the timeout. When the macro is undefined, the port and state are absent and the flow is unchanged.

Test Plan:
- Reset, bgn=1, load_done after 3 cycles, opcode=class000 -> read_file high for 4 cycles, get_addr 1 cycle, incr_pc 1 cycle, then fin=1 held; all other outputs 0.
- Load then store with reg_sel=1: load (opcode class001 sub=00) -> mem_read then reg_ld=2'b01; store (sub=01) -> reg_st=2'b01 then mem_write; each is followed by a return to get_addr.
- Branch on flags=4'b0100: sub=2 -> pc_from_imm pulse; sub=0 -> no pulse, next get_addr; sub=5 with NFLAGS=4 -> fault=1, fault_code=1.
- CALL ×8 then a 9th CALL with STACK_DEPTH=8 -> 8 push pulses, then fault_code=3. From reset, a single RET -> fault_code=4.
- EXEC unit 1, unit_done[1] after 5 cycles -> unit_start=2'b10 for 1 cycle, unit_save 1 cycle later. With TIMEOUT=16 and done never asserted -> fault_code=2 after 16 wait cycles.
- Assert rst mid EXEC_WAIT -> all outputs 0 asynchronously; a new bgn restarts from LOAD.
